// File: rtl/linear_array_frame_capture.sv
// Linear photodiode array frame capture: SI-triggered pixel capture into a ping-pong
// buffer, with per-frame peak value/index and pixel sum, plus a registered host read port.
module linear_array_frame_capture #(
    parameter int NUM_PIXELS = 128,
    parameter int DATA_W     = 8,
    parameter int PIX_OFFSET = 1,
    localparam int IW        = $clog2(NUM_PIXELS)
) (
    input  logic                 sensor_clk,
    input  logic                 reset,
    input  logic                 si_pulse,
    input  logic [DATA_W-1:0]    adc_data,
    input  logic [IW-1:0]        rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 frame_done,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic [DATA_W-1:0]    peak_value,
    output logic [IW-1:0]        peak_index,
    output logic [DATA_W+IW-1:0] pixel_sum
);

    localparam int SUM_W = DATA_W + IW;
    localparam logic [IW-1:0] LAST_PIX = IW'(NUM_PIXELS - 1);
    // The rise edge itself is delay clock 0, so DELAY holds PIX_OFFSET-1 cycles in total.
    localparam logic [3:0] DLY_INIT = (PIX_OFFSET > 1) ? 4'(PIX_OFFSET - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE} state_t;

    state_t              state_q, state_d;
    logic                si_q, si_d;
    logic [3:0]          dly_q, dly_d;
    logic [IW-1:0]       pix_q, pix_d;
    logic                wr_bank_q, wr_bank_d;
    logic [DATA_W-1:0]   run_max_q, run_max_d;
    logic [IW-1:0]       run_idx_q, run_idx_d;
    logic [SUM_W-1:0]    run_sum_q, run_sum_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_error_q, frame_error_d;
    logic [DATA_W-1:0]   peak_value_q, peak_value_d;
    logic [IW-1:0]       peak_index_q, peak_index_d;
    logic [SUM_W-1:0]    pixel_sum_q, pixel_sum_d;

    logic [DATA_W-1:0]   mem [2*NUM_PIXELS];
    logic                mem_we;
    logic [IW:0]         mem_waddr;

    logic                rise;
    logic [DATA_W-1:0]   cur_max;
    logic [IW-1:0]       cur_idx;
    logic [SUM_W-1:0]    cur_sum;

    // NOTE: every signal assigned in always_comb gets a default first, so no latches are inferred.
    always_comb begin
        rise          = si_pulse & ~si_q;
        si_d          = si_pulse;
        state_d       = state_q;
        dly_d         = dly_q;
        pix_d         = pix_q;
        wr_bank_d     = wr_bank_q;
        run_max_d     = run_max_q;
        run_idx_d     = run_idx_q;
        run_sum_d     = run_sum_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        frame_valid_d = frame_valid_q;
        peak_value_d  = peak_value_q;
        peak_index_d  = peak_index_q;
        pixel_sum_d   = pixel_sum_q;
        mem_we        = 1'b0;
        mem_waddr     = {wr_bank_q, pix_q};
        rd_data_d     = mem[{~wr_bank_q, rd_addr}];

        // Running statistics including the pixel on adc_data this cycle; pixel 0 seeds them.
        if (pix_q == '0) begin
            cur_max = adc_data;
            cur_idx = '0;
            cur_sum = SUM_W'(adc_data);
        end else begin
            cur_max = run_max_q;
            cur_idx = run_idx_q;
            if (adc_data > run_max_q) begin
                cur_max = adc_data;
                cur_idx = pix_q;
            end
            cur_sum = run_sum_q + SUM_W'(adc_data);
        end

        if (rise) begin
            frame_error_d = (state_q != S_IDLE);
            state_d       = (PIX_OFFSET == 1) ? S_CAPTURE : S_DELAY;
            dly_d         = DLY_INIT;
            pix_d         = '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_DELAY: begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - 4'd1;
                    end else begin
                        state_d = S_CAPTURE;
                        pix_d   = '0;
                    end
                end
                S_CAPTURE: begin
                    mem_we    = 1'b1;
                    run_max_d = cur_max;
                    run_idx_d = cur_idx;
                    run_sum_d = cur_sum;
                    pix_d     = pix_q + 1'b1;
                    if (pix_q == LAST_PIX) begin
                        state_d       = S_IDLE;
                        wr_bank_d     = ~wr_bank_q;
                        frame_done_d  = 1'b1;
                        frame_valid_d = 1'b1;
                        peak_value_d  = cur_max;
                        peak_index_d  = cur_idx;
                        pixel_sum_d   = cur_sum;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sensor_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            si_q          <= 1'b0;
            dly_q         <= '0;
            pix_q         <= '0;
            wr_bank_q     <= 1'b0;
            run_max_q     <= '0;
            run_idx_q     <= '0;
            run_sum_q     <= '0;
            rd_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            peak_value_q  <= '0;
            peak_index_q  <= '0;
            pixel_sum_q   <= '0;
        end else begin
            state_q       <= state_d;
            si_q          <= si_d;
            dly_q         <= dly_d;
            pix_q         <= pix_d;
            wr_bank_q     <= wr_bank_d;
            run_max_q     <= run_max_d;
            run_idx_q     <= run_idx_d;
            run_sum_q     <= run_sum_d;
            rd_data_q     <= rd_data_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            peak_value_q  <= peak_value_d;
            peak_index_q  <= peak_index_d;
            pixel_sum_q   <= pixel_sum_d;
        end
    end

    // NOTE: buffer RAM has no reset so it maps onto block RAM; only its read register is cleared.
    always_ff @(posedge sensor_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= adc_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign peak_value  = peak_value_q;
    assign peak_index  = peak_index_q;
    assign pixel_sum   = pixel_sum_q;

endmodule

// File: tb/tb_linear_array_frame_capture.sv
// Directed bench for linear_array_frame_capture: table of single-frame vectors plus
// hand-written sequences for back-to-back, early SI, held SI, mid-capture reset and offset 3.
module tb_linear_array_frame_capture;

    localparam int NP = 128;
    localparam int DW = 8;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          si_pulse = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [IW-1:0] rd_addr = '0;
    logic          use3 = 1'b0;

    logic [DW-1:0]    rd1, rd3, pk1, pk3;
    logic             done1, done3, valid1, valid3, err1, err3;
    logic [IW-1:0]    idx1, idx3;
    logic [DW+IW-1:0] sum1, sum3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    linear_array_frame_capture #(.NUM_PIXELS(NP), .DATA_W(DW), .PIX_OFFSET(1)) dut (
        .sensor_clk(clk), .reset(reset), .si_pulse(si_pulse), .adc_data(adc_data),
        .rd_addr(rd_addr), .rd_data(rd1), .frame_done(done1), .frame_valid(valid1),
        .frame_error(err1), .peak_value(pk1), .peak_index(idx1), .pixel_sum(sum1)
    );

    linear_array_frame_capture #(.NUM_PIXELS(NP), .DATA_W(DW), .PIX_OFFSET(3)) dut3 (
        .sensor_clk(clk), .reset(reset), .si_pulse(si_pulse), .adc_data(adc_data),
        .rd_addr(rd_addr), .rd_data(rd3), .frame_done(done3), .frame_valid(valid3),
        .frame_error(err3), .peak_value(pk3), .peak_index(idx3), .pixel_sum(sum3)
    );

    wire [DW-1:0]    f_rd    = use3 ? rd3 : rd1;
    wire             f_done  = use3 ? done3 : done1;
    wire             f_valid = use3 ? valid3 : valid1;
    wire             f_err   = use3 ? err3 : err1;
    wire [DW-1:0]    f_peak  = use3 ? pk3 : pk1;
    wire [IW-1:0]    f_idx   = use3 ? idx3 : idx1;
    wire [DW+IW-1:0] f_sum   = use3 ? sum3 : sum1;

    typedef struct {
        int pat;
        int exp_peak;
        int exp_idx;
        int exp_sum;
        int rd_a;
        int exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pix_val(input int pat, input int k);
        case (pat)
            0: return DW'(k);
            1: return (k == 40 || k == 90) ? 8'd200 : 8'd10;
            2: return DW'(255 - k);
            3: return 8'd0;
            4: return 8'd255;
            5: return (k == 127) ? 8'd9 : 8'd7;
            6: return 8'd5;
            7: return 8'd9;
            8: return (k == 3) ? 8'd250 : 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    // One frame: SI rise at the next edge, filler during the delay, then NP pixels.
    // Returns in the cycle where frame_done must be high.
    task automatic run_frame(input int pat, input int off, input bit rd_chk, input logic [DW-1:0] rd_exp);
        int spur = 0;
        si_pulse = 1'b1;
        adc_data = 8'hEE;
        tick();
        if (rd_chk) check("rd_at_done_cycle", f_rd, rd_exp);
        check("done_pulse_width", f_done, 0);
        spur += int'(f_err);
        si_pulse = 1'b0;
        for (int d = 1; d < off; d++) begin
            tick();
            spur += int'(f_done) + int'(f_err);
        end
        for (int k = 0; k < NP; k++) begin
            adc_data = pix_val(pat, k);
            tick();
            if (k < NP - 1) spur += int'(f_done) + int'(f_err);
        end
        adc_data = 8'hEE;
        check("frame_done", f_done, 1);
        check("frame_error_idle", f_err, 0);
        check("frame_valid", f_valid, 1);
        check("no_spurious_pulse", spur, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"}, rd1, 0);
        check({tag, "_frame_done"}, done1, 0);
        check({tag, "_frame_valid"}, valid1, 0);
        check({tag, "_frame_error"}, err1, 0);
        check({tag, "_peak_value"}, pk1, 0);
        check({tag, "_peak_index"}, idx1, 0);
        check({tag, "_pixel_sum"}, sum1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;

        vecs[0] = '{pat: 0, exp_peak: 127, exp_idx: 127, exp_sum: 8128,  rd_a: 5,   exp_rd: 5};
        vecs[1] = '{pat: 1, exp_peak: 200, exp_idx: 40,  exp_sum: 1660,  rd_a: 90,  exp_rd: 200};
        vecs[2] = '{pat: 2, exp_peak: 255, exp_idx: 0,   exp_sum: 24512, rd_a: 127, exp_rd: 128};
        vecs[3] = '{pat: 3, exp_peak: 0,   exp_idx: 0,   exp_sum: 0,     rd_a: 7,   exp_rd: 0};
        vecs[4] = '{pat: 4, exp_peak: 255, exp_idx: 0,   exp_sum: 32640, rd_a: 64,  exp_rd: 255};
        vecs[5] = '{pat: 5, exp_peak: 9,   exp_idx: 127, exp_sum: 898,   rd_a: 127, exp_rd: 9};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].pat, 1, 1'b0, '0);
            check($sformatf("v%0d_peak_value", i), f_peak, vecs[i].exp_peak);
            check($sformatf("v%0d_peak_index", i), f_idx, vecs[i].exp_idx);
            check($sformatf("v%0d_pixel_sum", i), f_sum, vecs[i].exp_sum);
            rd_addr = IW'(vecs[i].rd_a);
            tick();
            check($sformatf("v%0d_rd_data", i), f_rd, vecs[i].exp_rd);
            tick();
        end

        // Back-to-back frames on a 129-clock SI period.
        run_frame(6, 1, 1'b0, '0);
        rd_addr = 3;
        run_frame(7, 1, 1'b1, 8'd5);
        tick();
        check("b2b_rd_second", f_rd, 9);
        check("b2b_sum_second", f_sum, 1152);

        // Early SI 50 clocks into frame B aborts it and restarts.
        run_frame(6, 1, 1'b0, '0);
        pulses = 0;
        si_pulse = 1'b1;
        adc_data = 8'd9;
        tick();
        si_pulse = 1'b0;
        for (int j = 0; j < 49; j++) begin
            tick();
            pulses += int'(f_err) + int'(f_done);
        end
        check("abort_no_early_pulse", pulses, 0);
        si_pulse = 1'b1;
        tick();
        check("abort_frame_error", f_err, 1);
        check("abort_no_done", f_done, 0);
        si_pulse = 1'b0;
        check("abort_peak_kept", f_peak, 5);
        check("abort_sum_kept", f_sum, 640);
        rd_addr = 3;
        tick();
        n = 1;
        check("abort_rd_kept", f_rd, 5);
        check("abort_error_width", f_err, 0);
        while (!f_done && n < 400) begin
            tick();
            n++;
        end
        check("restart_commit_latency", n, 128);
        check("restart_peak", f_peak, 9);
        check("restart_sum", f_sum, 1152);
        tick();
        check("restart_rd", f_rd, 9);

        // SI held high for three cycles starts exactly one capture.
        tick();
        pulses = 0;
        si_pulse = 1'b1;
        adc_data = 8'hEE;
        tick();
        for (int k = 0; k < NP; k++) begin
            si_pulse = (k < 2);
            adc_data = pix_val(0, k);
            tick();
            if (k < NP - 1) pulses += int'(f_done) + int'(f_err);
        end
        si_pulse = 1'b0;
        check("held_si_done", f_done, 1);
        check("held_si_no_pulse", pulses, 0);
        check("held_si_peak", f_peak, 127);
        check("held_si_sum", f_sum, 8128);
        pulses = 0;
        for (int j = 0; j < 150; j++) begin
            tick();
            pulses += int'(f_done) + int'(f_err);
        end
        check("held_si_single_capture", pulses, 0);

        // Reset in the middle of a capture.
        si_pulse = 1'b1;
        adc_data = 8'hEE;
        tick();
        si_pulse = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            adc_data = pix_val(0, k);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        pulses = 0;
        for (int j = 0; j < 200; j++) begin
            adc_data = DW'(j);
            tick();
            pulses += int'(done1) + int'(err1);
        end
        check("midreset_no_pulse", pulses, 0);
        check("midreset_valid_low", valid1, 0);

        // PIX_OFFSET = 3 instance.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        use3 = 1'b1;
        check("off3_reset_valid", f_valid, 0);
        run_frame(8, 3, 1'b0, '0);
        check("off3_peak_value", f_peak, 250);
        check("off3_peak_index", f_idx, 3);
        check("off3_pixel_sum", f_sum, 377);
        rd_addr = 3;
        tick();
        check("off3_rd_3", f_rd, 250);
        rd_addr = 0;
        tick();
        check("off3_rd_0", f_rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
